// File: rtl/lcd_bus_seq_if.sv
// Host/LCD signal bundle for lcd_bus_seq; read-side signals exist only when
// LCD_READ_EN is defined.
interface lcd_bus_seq_if;
    logic       wr_stb;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       clr_ovr;
    logic       busy;
    logic       done;
    logic       ovr;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
`ifdef LCD_READ_EN
    logic       rd_stb;
    logic [7:0] lcd_din;
    logic [7:0] rd_data;

    modport master (
        output wr_stb, wr_rs, wr_data, clr_ovr, rd_stb, lcd_din,
        input  busy, done, ovr, lcd_data, lcd_rs, lcd_rw, lcd_en, rd_data
    );
    modport slave (
        input  wr_stb, wr_rs, wr_data, clr_ovr, rd_stb, lcd_din,
        output busy, done, ovr, lcd_data, lcd_rs, lcd_rw, lcd_en, rd_data
    );
`else
    modport master (
        output wr_stb, wr_rs, wr_data, clr_ovr,
        input  busy, done, ovr, lcd_data, lcd_rs, lcd_rw, lcd_en
    );
    modport slave (
        input  wr_stb, wr_rs, wr_data, clr_ovr,
        output busy, done, ovr, lcd_data, lcd_rs, lcd_rw, lcd_en
    );
`endif
endinterface

// File: rtl/lcd_bus_seq.sv
// HD44780 bus-cycle sequencer: setup, enable pulse, hold, execution gap.
// Optional read cycles are enabled with the LCD_READ_EN macro.
module lcd_bus_seq #(
    parameter int T_AS  = 4,
    parameter int T_PW  = 12,
    parameter int T_H   = 4,
    parameter int T_GAP = 2000,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    lcd_bus_seq_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_e;

    localparam logic [CW-1:0] AS_LD  = CW'(T_AS - 1);
    localparam logic [CW-1:0] PW_LD  = CW'(T_PW - 1);
    localparam logic [CW-1:0] H_LD   = CW'(T_H - 1);
    localparam logic [CW-1:0] GAP_LD = (T_GAP > 0) ? CW'(T_GAP - 1) : '0;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          rd_req;
    logic          cnt_zero;
`ifdef LCD_READ_EN
    logic          rw_q, rw_d;
    logic [7:0]    rd_data_q, rd_data_d;
    assign rd_req = bus.rd_stb;
`else
    assign rd_req = 1'b0;
`endif

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        data_d  = data_q;
        rs_d    = rs_q;
`ifdef LCD_READ_EN
        rw_d      = rw_q;
        rd_data_d = rd_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.wr_stb) begin
                    data_d  = bus.wr_data;
                    rs_d    = bus.wr_rs;
                    state_d = S_SETUP;
                    cnt_d   = AS_LD;
`ifdef LCD_READ_EN
                    rw_d    = 1'b0;
`endif
                end else if (rd_req) begin
                    // Reads reuse wr_rs to choose busy-flag vs data RAM.
                    rs_d    = bus.wr_rs;
                    state_d = S_SETUP;
                    cnt_d   = AS_LD;
`ifdef LCD_READ_EN
                    rw_d    = 1'b1;
`endif
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_PULSE;
                    cnt_d   = PW_LD;
                    en_d    = 1'b1;
                end else cnt_d = cnt_q - 1'b1;
            end
            S_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = H_LD;
                    en_d    = 1'b0;
`ifdef LCD_READ_EN
                    if (rw_q) rd_data_d = bus.lcd_din;
`endif
                end else cnt_d = cnt_q - 1'b1;
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    if (T_GAP > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`ifdef LCD_READ_EN
                        rw_d    = 1'b0;
`endif
                    end
                end else cnt_d = cnt_q - 1'b1;
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`ifdef LCD_READ_EN
                    rw_d    = 1'b0;
`endif
                end else cnt_d = cnt_q - 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                en_d    = 1'b0;
            end
        endcase

        // A strobe on the completion edge is still dropped; the set wins over clr_ovr.
        if (bus.clr_ovr) ovr_d = 1'b0;
        if ((state_q != S_IDLE && (bus.wr_stb || rd_req)) ||
            (state_q == S_IDLE && bus.wr_stb && rd_req))
            ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
`ifdef LCD_READ_EN
            rw_q      <= 1'b0;
            rd_data_q <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
`ifdef LCD_READ_EN
            rw_q      <= rw_d;
            rd_data_q <= rd_data_d;
`endif
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.ovr      = ovr_q;
    assign bus.lcd_data = data_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_en   = en_q;
`ifdef LCD_READ_EN
    assign bus.lcd_rw   = rw_q;
    assign bus.rd_data  = rd_data_q;
`else
    assign bus.lcd_rw   = 1'b0;
`endif
endmodule

// File: tb/tb_lcd_bus_seq.sv
// Random-stimulus bench for lcd_bus_seq: two instances (with and without an
// execution gap) checked against a cycle-count reference model.
module tb_lcd_bus_seq;
    localparam int AS  [2] = '{3, 1};
    localparam int PW  [2] = '{4, 1};
    localparam int HD  [2] = '{2, 1};
    localparam int GAP [2] = '{6, 0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_bus_seq_if if0 ();
    lcd_bus_seq_if if1 ();

    lcd_bus_seq #(.T_AS(3), .T_PW(4), .T_H(2), .T_GAP(6), .CW(8)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    lcd_bus_seq #(.T_AS(1), .T_PW(1), .T_H(1), .T_GAP(0), .CW(4)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave));

    int n_chk  = 0;
    int n_fail = 0;

    // model: each transfer is just "cycles elapsed since accept"
    bit         act [2];
    int         k   [2];
    logic [7:0] md  [2];
    logic       mrs [2];
    logic       movr[2];

    logic       stb, rs_in, clr;
    logic [7:0] din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        if0.wr_stb = stb; if0.wr_rs = rs_in; if0.wr_data = din; if0.clr_ovr = clr;
        if1.wr_stb = stb; if1.wr_rs = rs_in; if1.wr_data = din; if1.clr_ovr = clr;
`ifdef LCD_READ_EN
        if0.rd_stb = 1'b0; if0.lcd_din = 8'h00;
        if1.rd_stb = 1'b0; if1.lcd_din = 8'h00;
`endif
    endtask

    function automatic int total(input int i);
        return AS[i] + PW[i] + HD[i] + GAP[i];
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit busy_pre;
            if (rst) begin
                act[i] = 0; k[i] = 0; md[i] = 8'h00; mrs[i] = 1'b0; movr[i] = 1'b0;
            end else begin
                busy_pre = act[i] && (k[i] < total(i));
                if (act[i]) k[i]++;
                if (stb && busy_pre) movr[i] = 1'b1;
                else if (clr) movr[i] = 1'b0;
                if (stb && !busy_pre) begin
                    act[i] = 1; k[i] = 0; md[i] = din; mrs[i] = rs_in;
                end
            end
        end
    endtask

    task automatic check_outputs(input int i);
        logic busy, done, ovr, en, rs, rw;
        logic [7:0] dat;
        bit eb, ed, ee;
        if (i == 0) begin
            busy = if0.busy; done = if0.done; ovr = if0.ovr; en = if0.lcd_en;
            rs = if0.lcd_rs; rw = if0.lcd_rw; dat = if0.lcd_data;
        end else begin
            busy = if1.busy; done = if1.done; ovr = if1.ovr; en = if1.lcd_en;
            rs = if1.lcd_rs; rw = if1.lcd_rw; dat = if1.lcd_data;
        end
        eb = act[i] && (k[i] < total(i));
        ed = act[i] && (k[i] == total(i));
        ee = act[i] && (k[i] >= AS[i]) && (k[i] < AS[i] + PW[i]);
        check($sformatf("u%0d.busy", i),     32'(busy), 32'(eb));
        check($sformatf("u%0d.done", i),     32'(done), 32'(ed));
        check($sformatf("u%0d.ovr", i),      32'(ovr),  32'(movr[i]));
        check($sformatf("u%0d.lcd_en", i),   32'(en),   32'(ee));
        check($sformatf("u%0d.lcd_data", i), 32'(dat),  32'(md[i]));
        check($sformatf("u%0d.lcd_rs", i),   32'(rs),   32'(mrs[i]));
        check($sformatf("u%0d.lcd_rw", i),   32'(rw),   32'd0);
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(0);
        check_outputs(1);
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; rs_in = 1'b0; clr = 1'b0; din = 8'h00;
        @(negedge clk);
        step();
        rst = 1'b0;
        repeat (5) step();

        // directed: data write 0x41, then a dropped strobe mid-cycle
        stb = 1'b1; rs_in = 1'b1; din = 8'h41; step();
        stb = 1'b0; repeat (9) step();
        stb = 1'b1; rs_in = 1'b0; din = 8'hC3; step();
        stb = 1'b0; clr = 1'b1; step();
        clr = 1'b0; stb = 1'b1; clr = 1'b1; step();
        stb = 1'b0; clr = 1'b0; repeat (20) step();

        for (int cyc = 0; cyc < 1600; cyc++) begin
            int mode;
            mode  = cyc / 400;
            din   = 8'($urandom);
            rs_in = 1'($urandom);
            clr   = ($urandom_range(0, 11) == 0);
            case (mode)
                0:       stb = ($urandom_range(0, 7) == 0);
                1:       stb = ($urandom_range(0, 1) == 0);
                2:       stb = 1'b1;
                default: stb = ($urandom_range(0, 4) == 0);
            endcase
            rst = (mode == 3) && ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0; stb = 1'b0; clr = 1'b0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
